pixels_kept_seq: RTL and testbench
==================================

# pixels_kept_seq

Sequential, parametrised successor to the combinational pixels-kept estimator. It accepts the four corners of the projected quadrilateral through a start/done handshake. It computes the exact doubled area with the shoelace-diagonal formula, then the exact percentage of the H_RES×V_RES frame covered, using a 7-step restoring divider instead of a shift-add approximation. It also reports orientation, degeneracy and saturation. It sits between the corner-tracking logic and the on-screen status display.

## Interface
- XW, 10, x coordinate width (unsigned)
- YW, 9, y coordinate width (unsigned)
- H_RES, 640, frame width in pixels
- V_RES, 480, frame height in pixels
- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- x1..x4  input  XW each  corner x coordinates, latched on accepted start
- y1..y4  input  YW each  corner y coordinates, latched on accepted start
- busy  output  1  high whenever state ≠ IDLE
- done  output  1  one-cycle pulse, results valid
- percent_kept  output  7  floor(100·A2 / (2·H_RES·V_RES)), clamped to 100
- area2  output  XW+YW+2  |doubled signed area| (A2)
- orient  output  1  1 when signed doubled area < 0
- degenerate  output  1  1 when A2 == 0
- saturated  output  1  1 when A2 > 2·H_RES·V_RES (percent clamped)

## Operation
- Width rules:
  - Zero-extend coordinates by 1 bit to signed.
  - dx13 = x1−x3 and dx24 = x2−x4 are XW+1 bits; dy13 and dy24 are YW+1 bits.
  - prod = dx13·dy24 − dy13·dx24, held signed at XW+YW+3 bits.
  - A2 = |prod|, which fits in XW+YW+2 unsigned bits.
- Denominator D = 2·H_RES·V_RES, a localparam constant.
- Numerator N = 100·A2 (XW+YW+9 bits), formed as a shift-add (64+32+4).
- FSM, one state per cycle unless noted:
  - IDLE: on start=1, latch all eight coordinates and go to DIFF.
  - DIFF: register the four differences.
  - MULT: register both products.
  - ABS: register prod sign (→ orient), A2, and the A2==0 flag.
  - SCALE: register N.
    - Set the saturated flag if A2 > D.
    - Clear the quotient and remainder.
  - DIV: runs exactly 7 cycles, one restoring-division step per cycle, MSB of the quotient first. The quotient has 7 bits, so it is valid for N < 128·D.
  - DONE: update the outputs, then go to IDLE.
    - percent_kept = saturated ? 100 : quotient.
    - area2 = A2 when not saturated; when saturated, area2 still carries the true A2.
    - orient, degenerate and saturated take the registered values.
    - done = 1.
- start is ignored in every state other than IDLE; no queueing.
- Input coordinates may change freely after the cycle in which start is accepted.
- Fixed latency regardless of data, including the degenerate and saturated cases.

## Timing
- Let cycle 0 be the cycle in which start=1 is sampled in IDLE.
- busy = 1 in cycles 1–12.
- done = 1 in cycle 12 only; all result outputs are valid from cycle 12 onward.
- Result outputs hold until the next DONE; they are not cleared by returning to IDLE.
- The FSM is back in IDLE in cycle 13, so a start can be accepted in cycle 13. Maximum throughput is one result per 13 cycles.
- Reset: synchronous.
  - State goes to IDLE.
  - busy, done, percent_kept, area2, orient, degenerate and saturated all go to 0.
- Reset mid-operation aborts the computation: no done pulse, outputs are zero the cycle after reset.
- Reset has priority over start in the same cycle.

## Test plan
- Full-frame rectangle (0,0),(639,0),(639,479),(0,479) → done at cycle 12; area2=612162, percent_kept=99, orient=0, degenerate=0, saturated=0.
- Left half (0,0),(319,0),(319,479),(0,479) → area2=305602, percent_kept=49. The same rectangle with corner order reversed → identical area2 and percent_kept, orient=1.
- All corners at (100,100) → area2=0, percent_kept=0, degenerate=1, done still at cycle 12.
- Oversized (0,0),(1023,0),(1023,511),(0,511) → area2=1045506, saturated=1, percent_kept=100.
- Pulse start again in cycles 3 and 12 → both ignored, exactly one done. A start in cycle 13 is accepted, with its done in cycle 25.
- Assert reset in cycle 6 → in cycle 7, busy=0 and all outputs are 0; no done appears.

Source files
------------

// File: rtl/pixels_kept_seq_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixels_kept_seq_if : corner/result bundle for pixels_kept_seq  (rev 1.0) |
// +--------------------------------------------------------------------------+
interface pixels_kept_seq_if #(
  parameter int XW = 10,
  parameter int YW = 9
);
  logic              start;
  logic [XW-1:0]     x1, x2, x3, x4;
  logic [YW-1:0]     y1, y2, y3, y4;
  logic              busy;
  logic              done;
  logic [6:0]        percent_kept;
  logic [XW+YW+1:0]  area2;
  logic              orient;
  logic              degenerate;
  logic              saturated;

  modport master (
    output start, x1, x2, x3, x4, y1, y2, y3, y4,
    input  busy, done, percent_kept, area2, orient, degenerate, saturated
  );

  modport slave (
    input  start, x1, x2, x3, x4, y1, y2, y3, y4,
    output busy, done, percent_kept, area2, orient, degenerate, saturated
  );
endinterface
`default_nettype wire

// File: rtl/pixels_kept_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pixels_kept_seq : exact quad area and frame-coverage percent  (rev 1.0)  |
// +--------------------------------------------------------------------------+
module pixels_kept_seq #(
  parameter int XW    = 10,
  parameter int YW    = 9,
  parameter int H_RES = 640,
  parameter int V_RES = 480
) (
  input  logic              clk,
  input  logic              reset,
  pixels_kept_seq_if.slave  bus
);

  localparam int AW = XW + YW + 2;
  localparam int PW = XW + YW + 3;
  localparam int NW = XW + YW + 9;
  // Remainder is widened so the divisor shifted by 6 never overflows.
  localparam int RW = NW + 7;
  localparam logic [RW-1:0] DEN = RW'(2 * H_RES * V_RES);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DIFF  = 3'd1,
    MULT  = 3'd2,
    ABS   = 3'd3,
    SCALE = 3'd4,
    DIV   = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t               state;
  logic [XW-1:0]        xa, xb, xc, xd;
  logic [YW-1:0]        ya, yb, yc, yd;
  logic signed [XW:0]   dx13, dx24;
  logic signed [YW:0]   dy13, dy24;
  logic signed [PW-1:0] p1, p2;
  logic                 neg;
  logic                 zero;
  logic                 sat;
  logic [AW-1:0]        a2;
  logic [RW-1:0]        rem;
  logic [6:0]           quo;
  logic [2:0]           step;

  logic                 busy_q, done_q, orient_q, degen_q, sat_q;
  logic [6:0]           pct_q;
  logic [AW-1:0]        area_q;

  logic signed [PW-1:0] prod;
  logic [RW-1:0]        dsh;
  logic                 ge;

  assign prod = p1 - p2;
  assign dsh  = DEN << step;
  assign ge   = (rem >= dsh);

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.percent_kept = pct_q;
  assign bus.area2        = area_q;
  assign bus.orient       = orient_q;
  assign bus.degenerate   = degen_q;
  assign bus.saturated    = sat_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pct_q    <= '0;
      area_q   <= '0;
      orient_q <= 1'b0;
      degen_q  <= 1'b0;
      sat_q    <= 1'b0;
      step     <= '0;
      quo      <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            xa <= bus.x1; xb <= bus.x2; xc <= bus.x3; xd <= bus.x4;
            ya <= bus.y1; yb <= bus.y2; yc <= bus.y3; yd <= bus.y4;
            busy_q <= 1'b1;
            state  <= DIFF;
          end
        end
        DIFF: begin
          dx13  <= $signed({1'b0, xa}) - $signed({1'b0, xc});
          dx24  <= $signed({1'b0, xb}) - $signed({1'b0, xd});
          dy13  <= $signed({1'b0, ya}) - $signed({1'b0, yc});
          dy24  <= $signed({1'b0, yb}) - $signed({1'b0, yd});
          state <= MULT;
        end
        MULT: begin
          p1    <= PW'(dx13) * PW'(dy24);
          p2    <= PW'(dy13) * PW'(dx24);
          state <= ABS;
        end
        ABS: begin
          neg   <= prod[PW-1];
          a2    <= AW'(prod[PW-1] ? -prod : prod);
          zero  <= (prod == '0);
          state <= SCALE;
        end
        SCALE: begin
          // 100*A2 as 64+32+4
          rem   <= (RW'(a2) << 6) + (RW'(a2) << 5) + (RW'(a2) << 2);
          sat   <= (RW'(a2) > DEN);
          quo   <= '0;
          step  <= 3'd6;
          state <= DIV;
        end
        DIV: begin
          if (ge) rem <= rem - dsh;
          quo[step] <= ge;
          if (step == 3'd0) begin
            pct_q    <= sat ? 7'd100 : {quo[6:1], ge};
            area_q   <= a2;
            orient_q <= neg;
            degen_q  <= zero;
            sat_q    <= sat;
            done_q   <= 1'b1;
            state    <= DONE;
          end else begin
            step <= step - 3'd1;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pixels_kept_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pixels_kept_seq : bench for pixels_kept_seq                 (rev 1.0) |
// +--------------------------------------------------------------------------+
module tb_pixels_kept_seq;

  localparam longint DENOM = 2 * 640 * 480;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  pixels_kept_seq_if #(.XW(10), .YW(9)) bus ();

  pixels_kept_seq #(.XW(10), .YW(9), .H_RES(640), .V_RES(480)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    longint a2;
    longint pct;
    bit     ori;
    bit     deg;
    bit     sat;
  } res_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int done_count = 0;

  function automatic res_t model(input longint x1, y1, x2, y2, x3, y3, x4, y4);
    res_t   r;
    longint s;
    s     = (x1 - x3) * (y2 - y4) - (y1 - y3) * (x2 - x4);
    r.ori = (s < 0);
    r.a2  = (s < 0) ? -s : s;
    r.deg = (r.a2 == 0);
    r.sat = (r.a2 > DENOM);
    r.pct = r.sat ? 100 : (100 * r.a2) / DENOM;
    return r;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  // Cycle-level model: tracks accepted jobs and compares every cycle after reset.
  initial begin
    bit     armed, s_rst, s_start;
    longint idle_at, done_at;
    res_t   nr, pend, cur;
    armed = 0; idle_at = 0; done_at = -1;
    cur  = '{default: 0};
    pend = '{default: 0};
    forever begin
      @(posedge clk);
      s_rst   = reset;
      s_start = bus.start;
      nr = model(bus.x1, bus.y1, bus.x2, bus.y2, bus.x3, bus.y3, bus.x4, bus.y4);
      #1;
      cyc++;
      if (s_rst) begin
        armed   = 1;
        idle_at = cyc;
        done_at = -1;
        cur     = '{default: 0};
      end else if (armed && s_start && (cyc - 1) >= idle_at) begin
        pend    = nr;
        done_at = cyc + 11;
        idle_at = cyc + 12;
      end
      if (cyc == done_at) cur = pend;
      if (armed) begin
        check("busy",       bus.busy,         64'(cyc < idle_at));
        check("done",       bus.done,         64'(cyc == done_at));
        check("percent",    bus.percent_kept, cur.pct);
        check("area2",      bus.area2,        cur.a2);
        check("orient",     bus.orient,       64'(cur.ori));
        check("degenerate", bus.degenerate,   64'(cur.deg));
        check("saturated",  bus.saturated,    64'(cur.sat));
      end
      if (bus.done === 1'b1) done_count++;
    end
  end

  task automatic set_xy(input int x1, y1, x2, y2, x3, y3, x4, y4);
    bus.x1 = 10'(x1); bus.y1 = 9'(y1);
    bus.x2 = 10'(x2); bus.y2 = 9'(y2);
    bus.x3 = 10'(x3); bus.y3 = 9'(y3);
    bus.x4 = 10'(x4); bus.y4 = 9'(y4);
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Issues one job, scrambles the inputs afterwards, returns at the done cycle.
  task automatic job(input int x1, y1, x2, y2, x3, y3, x4, y4, output int acc, output int lat);
    @(negedge clk);
    set_xy(x1, y1, x2, y2, x3, y3, x4, y4);
    bus.start = 1'b1;
    acc = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    set_xy(1023, 511, 7, 3, 512, 0, 0, 256);
    lat = -1;
    for (int i = 0; i < 20 && lat < 0; i++) begin
      if (bus.done === 1'b1) lat = cyc - acc;
      else @(negedge clk);
    end
    check("latency", 64'(lat), 64'd12);
  endtask

  task automatic expect_out(input string tag, input int area, pct, ori, deg, sat);
    check({tag, ".area2"},   bus.area2,        64'(area));
    check({tag, ".percent"}, bus.percent_kept, 64'(pct));
    check({tag, ".orient"},  bus.orient,       64'(ori));
    check({tag, ".degen"},   bus.degenerate,   64'(deg));
    check({tag, ".sat"},     bus.saturated,    64'(sat));
  endtask

  initial begin
    int acc, lat, d0;
    res_t m;
    bus.start = 1'b0;
    set_xy(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    expect_out("reset", 0, 0, 0, 0, 0);
    check("reset.busy", bus.busy, 64'd0);

    m = model(0, 0, 639, 0, 639, 479, 0, 479);
    check("model.full", 64'(m.a2), 64'd612162);

    job(0, 0, 639, 0, 639, 479, 0, 479, acc, lat);
    expect_out("full", 612162, 99, 0, 0, 0);
    job(0, 0, 319, 0, 319, 479, 0, 479, acc, lat);
    expect_out("left", 305602, 49, 0, 0, 0);
    job(0, 479, 319, 479, 319, 0, 0, 0, acc, lat);
    expect_out("leftrev", 305602, 49, 1, 0, 0);
    job(100, 100, 100, 100, 100, 100, 100, 100, acc, lat);
    expect_out("degen", 0, 0, 0, 1, 0);
    job(0, 0, 1023, 0, 1023, 511, 0, 511, acc, lat);
    expect_out("over", 1045506, 100, 0, 0, 1);
    job(0, 0, 640, 0, 640, 480, 0, 480, acc, lat);
    expect_out("exactD", 614400, 100, 0, 0, 0);
    job(10, 20, 300, 40, 200, 400, 5, 300, acc, lat);
    job(700, 10, 20, 30, 650, 500, 900, 400, acc, lat);

    // Starts during cycles 3 and 12 are ignored; the one in cycle 13 is accepted.
    @(negedge clk);
    d0 = done_count;
    set_xy(0, 0, 639, 0, 639, 479, 0, 479);
    bus.start = 1'b1;
    acc = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    wait_until(acc + 3);
    set_xy(0, 0, 1023, 0, 1023, 511, 0, 511);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_until(acc + 12);
    check("ovl.done12", bus.done, 64'd1);
    expect_out("ovl", 612162, 99, 0, 0, 0);
    set_xy(100, 100, 100, 100, 100, 100, 100, 100);
    bus.start = 1'b1;
    @(negedge clk);
    set_xy(0, 0, 319, 0, 319, 479, 0, 479);
    @(negedge clk);
    bus.start = 1'b0;
    wait_until(acc + 25);
    check("ovl.done25", bus.done, 64'd1);
    check("ovl.count", 64'(done_count - d0), 64'd2);
    expect_out("ovl2", 305602, 49, 0, 0, 0);

    // Reset in cycle 6 aborts the job.
    @(negedge clk);
    d0 = done_count;
    set_xy(0, 0, 639, 0, 639, 479, 0, 479);
    bus.start = 1'b1;
    acc = cyc;
    @(negedge clk);
    bus.start = 1'b0;
    wait_until(acc + 6);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("rst.busy", bus.busy, 64'd0);
    check("rst.done", bus.done, 64'd0);
    expect_out("rst", 0, 0, 0, 0, 0);
    wait_until(acc + 22);
    check("rst.nodone", 64'(done_count - d0), 64'd0);

    job(0, 479, 319, 479, 319, 0, 0, 0, acc, lat);
    expect_out("after", 305602, 49, 1, 0, 0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
